// File: rtl/bgs_pkg.sv
// Shared types and helpers for the background-subtraction engine.
// Holds the FSM state enum, the pixel-mode encodings and the luma function.
package bgs_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CALC,
        S_WR,
        S_OUT
    } state_t;

    typedef enum logic [1:0] {
        M_BYPASS = 2'b00,
        M_LEARN  = 2'b01,
        M_DETECT = 2'b10
    } mode_t;

    // The spare encoding 2'b11 behaves as DETECT.
    function automatic mode_t decode_mode(input logic [1:0] m);
        unique case (m)
            2'b00:   return M_BYPASS;
            2'b01:   return M_LEARN;
            default: return M_DETECT;
        endcase
    endfunction

    // (r + 2g + b) >> 2 on zero-extended 16-bit channels; 18 bits never overflow.
    function automatic logic [17:0] luma18(
        input logic [15:0] r,
        input logic [15:0] g,
        input logic [15:0] b
    );
        logic [17:0] s;
        s = 18'(r) + (18'(g) << 1) + 18'(b);
        return s >> 2;
    endfunction

endpackage

// File: rtl/bgs_addr_counter.sv
// Frame address counter: wraps at the last pixel, forced to 0 by sof,
// and flags frame_done during the OUT cycle of the last pixel.
module bgs_addr_counter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic              i_sof,
    input  logic              i_out,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic              o_frame_done
);

    localparam int NPIX = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_last;

    assign o_pix_addr   = i_sof ? '0 : r_cnt;
    assign o_frame_done = i_out & r_last;

    // Advance past the accepted pixel and remember whether it closes the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_accept) begin
            r_cnt  <= (o_pix_addr == LAST) ? '0 : o_pix_addr + ADDR_W'(1);
            r_last <= (o_pix_addr == LAST);
        end
    end

endmodule

// File: rtl/bg_sub_engine.sv
// Running-average background subtraction with an external 16-bit SRAM.
// Optional macro BGS_SELECTIVE_UPDATE_EN: foreground pixels skip write-back.
module bg_sub_engine
    import bgs_pkg::*;
#(
    parameter int PIX_W    = 10,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int ADDR_W   = 20,
    parameter int ALPHA_SH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sof,
    input  logic [PIX_W-1:0]  i_r,
    input  logic [PIX_W-1:0]  i_g,
    input  logic [PIX_W-1:0]  i_b,
    input  logic [1:0]        i_mode,
    input  logic [PIX_W-1:0]  i_thresh,
    output logic              o_sram_req,
    input  logic              i_sram_ack,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    input  logic [15:0]       i_sram_rdata,
    output logic              o_valid,
    output logic              o_fg,
    output logic [PIX_W-1:0]  o_diff,
    output logic              o_frame_done,
    output logic [ADDR_W-1:0] o_fg_count
);

    localparam int SH = 16 - PIX_W;

    state_t            r_state;
    state_t            w_next;
    mode_t             r_mode;
    mode_t             w_pmode;
    logic              r_live;
    logic              w_accept;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  w_y;
    logic [PIX_W-1:0]  r_y;
    logic [PIX_W-1:0]  r_b;
    logic [PIX_W-1:0]  w_diff;
    logic [PIX_W-1:0]  w_step;
    logic [PIX_W-1:0]  w_bn;
    logic              w_fg;
    logic [15:0]       r_wdata;
    logic              r_fgw;
    logic [PIX_W-1:0]  r_dfw;
    logic              r_fg;
    logic [PIX_W-1:0]  r_diff;
    logic [ADDR_W-1:0] r_fgcnt;
    logic [ADDR_W-1:0] r_fgcount;
    logic              w_fd;

    assign w_accept = (r_state == S_IDLE) & r_live & i_valid;
    assign w_pmode  = (w_pix_addr == '0) ? decode_mode(i_mode) : r_mode;
    assign w_y      = PIX_W'(luma18(16'(i_r), 16'(i_g), 16'(i_b)));
    assign w_diff   = (r_y >= r_b) ? r_y - r_b : r_b - r_y;
    assign w_step   = w_diff >> ALPHA_SH;
    assign w_bn     = (r_y >= r_b) ? r_b + w_step : r_b - w_step;
    assign w_fg     = (w_diff > i_thresh);

    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_fg         = r_fg;
    assign o_diff       = r_diff;
    assign o_fg_count   = r_fgcount;
    assign o_frame_done = w_fd;

    bgs_addr_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_accept     (w_accept),
        .i_sof        (i_sof),
        .i_out        (r_state == S_OUT),
        .o_pix_addr   (w_pix_addr),
        .o_frame_done (w_fd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next     = r_state;
        o_ready    = 1'b0;
        o_sram_req = 1'b0;
        o_sram_we  = 1'b0;
        o_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_ready = r_live;
                if (w_accept) begin
                    unique case (w_pmode)
                        M_DETECT: w_next = S_RD;
                        M_LEARN:  w_next = S_WR;
                        default:  w_next = S_OUT;
                    endcase
                end
            end
            S_RD: begin
                o_sram_req = 1'b1;
                if (i_sram_ack) w_next = S_CALC;
            end
            S_CALC: begin
`ifdef BGS_SELECTIVE_UPDATE_EN
                w_next = w_fg ? S_OUT : S_WR;
`else
                w_next = S_WR;
`endif
            end
            S_WR: begin
                o_sram_req = 1'b1;
                o_sram_we  = 1'b1;
                if (i_sram_ack) w_next = S_OUT;
            end
            S_OUT: begin
                o_valid = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pixel datapath, result registers and per-frame foreground count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_mode    <= M_BYPASS;
            r_addr    <= '0;
            r_y       <= '0;
            r_b       <= '0;
            r_wdata   <= '0;
            r_fgw     <= 1'b0;
            r_dfw     <= '0;
            r_fg      <= 1'b0;
            r_diff    <= '0;
            r_fgcnt   <= '0;
            r_fgcount <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_y     <= w_y;
                r_addr  <= w_pix_addr;
                r_wdata <= 16'(w_y) << SH;
                r_fgw   <= 1'b0;
                r_dfw   <= '0;
                if (w_pix_addr == '0) r_mode <= w_pmode;
                if (i_sof) r_fgcnt <= '0;
            end
            if (r_state == S_RD && i_sram_ack) begin
                r_b <= PIX_W'(i_sram_rdata >> SH);
            end
            if (r_state == S_CALC) begin
                r_fgw   <= w_fg;
                r_dfw   <= w_diff;
                r_wdata <= 16'(w_bn) << SH;
            end
            if (w_next == S_OUT && r_state != S_OUT) begin
                unique case (r_state)
                    S_CALC: begin
                        r_fg   <= w_fg;
                        r_diff <= w_diff;
                    end
                    S_WR: begin
                        r_fg   <= r_fgw;
                        r_diff <= r_dfw;
                    end
                    default: begin
                        r_fg   <= 1'b0;
                        r_diff <= '0;
                    end
                endcase
            end
            if (r_state == S_OUT) begin
                if (w_fd) begin
                    r_fgcount <= r_fgcnt + ADDR_W'(r_fg);
                    r_fgcnt   <= '0;
                end else begin
                    r_fgcnt <= r_fgcnt + ADDR_W'(r_fg);
                end
            end
        end
    end

endmodule

// File: tb/tb_bg_sub_engine.sv
// Bench for bg_sub_engine on a 16x8 frame with a behavioural SRAM
// and a spec-level pixel model feeding a scoreboard.
module tb_bg_sub_engine;

    localparam int PIX_W  = 10;
    localparam int H_RES  = 16;
    localparam int V_RES  = 8;
    localparam int ADDR_W = 7;
    localparam int ASH    = 3;
    localparam int NPIX   = H_RES * V_RES;
`ifdef BGS_SELECTIVE_UPDATE_EN
    localparam bit SEL = 1'b1;
`else
    localparam bit SEL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid;
    logic              o_ready;
    logic              i_sof;
    logic [PIX_W-1:0]  i_r, i_g, i_b;
    logic [1:0]        i_mode;
    logic [PIX_W-1:0]  i_thresh;
    logic              o_sram_req;
    logic              i_sram_ack;
    logic              o_sram_we;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [15:0]       o_sram_wdata;
    logic [15:0]       i_sram_rdata;
    logic              o_valid;
    logic              o_fg;
    logic [PIX_W-1:0]  o_diff;
    logic              o_frame_done;
    logic [ADDR_W-1:0] o_fg_count;

    bg_sub_engine #(
        .PIX_W    (PIX_W),
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .ADDR_W   (ADDR_W),
        .ALPHA_SH (ASH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_sof        (i_sof),
        .i_r          (i_r),
        .i_g          (i_g),
        .i_b          (i_b),
        .i_mode       (i_mode),
        .i_thresh     (i_thresh),
        .o_sram_req   (o_sram_req),
        .i_sram_ack   (i_sram_ack),
        .o_sram_we    (o_sram_we),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata),
        .o_valid      (o_valid),
        .o_fg         (o_fg),
        .o_diff       (o_diff),
        .o_frame_done (o_frame_done),
        .o_fg_count   (o_fg_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [15:0]       mem [NPIX];
    int                ack_dly = 0;
    int                req_cyc = 0;
    int                n_acc = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] h_addr;
    logic              h_we;
    logic [15:0]       h_wd;

    always @(negedge clk) begin
        if (rst_n && o_sram_req) begin
            if (req_cyc == 0) begin
                h_addr = o_sram_addr;
                h_we   = o_sram_we;
                h_wd   = o_sram_wdata;
            end else begin
                chk("sram_addr_hold", o_sram_addr, h_addr);
                chk("sram_we_hold", o_sram_we, h_we);
                chk("sram_wdata_hold", o_sram_wdata, h_wd);
                chk("ready_busy", o_ready, 0);
            end
            if (req_cyc >= ack_dly) begin
                i_sram_ack   = 1'b1;
                i_sram_rdata = mem[o_sram_addr];
                last_addr    = o_sram_addr;
                n_acc++;
                req_cyc = 0;
            end else begin
                i_sram_ack = 1'b0;
                req_cyc++;
            end
        end else begin
            i_sram_ack = 1'b0;
            req_cyc = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && i_sram_ack && o_sram_req && o_sram_we)
            mem[o_sram_addr] = o_sram_wdata;
    end

    // ---------------- pixel model ----------------
    typedef struct {
        logic fg;
        int   diff;
        logic fd;
        int   lat;
        int   acc_cyc;
        int   acc_base;
        int   nacc;
        int   addr;
        logic wr;
        int   wd;
        int   cnt_now;
        int   cnt_next;
    } exp_t;

    exp_t q[$];
    int   m_bg [NPIX];
    int   m_cnt = 0;
    int   m_mode = 0;
    int   m_fgacc = 0;
    int   m_fgout = 0;
    int   fd_cnt = 0;

    function automatic exp_t model(input int r, input int g, input int b,
                                   input bit sof, input int mode, input int th);
        exp_t e;
        int y, a, bv, d, st, bn;
        y = ((r + 2 * g + b) / 4) % (1 << PIX_W);
        a = sof ? 0 : m_cnt;
        if (a == 0) m_mode = (mode == 0) ? 0 : (mode == 1) ? 1 : 2;
        if (sof) m_fgacc = 0;
        e.fg = 0; e.diff = 0; e.nacc = 0; e.wr = 0; e.wd = 0;
        e.addr = a; e.lat = 1;
        if (m_mode == 1) begin
            m_bg[a] = y;
            e.wr = 1; e.wd = y * 64; e.nacc = 1; e.lat = 2;
        end else if (m_mode == 2) begin
            bv = m_bg[a];
            d  = (y >= bv) ? y - bv : bv - y;
            st = d >> ASH;
            bn = (y >= bv) ? bv + st : bv - st;
            e.fg = (d > th);
            e.diff = d;
            if (SEL && e.fg) begin
                e.nacc = 1; e.lat = 3;
            end else begin
                m_bg[a] = bn;
                e.wr = 1; e.wd = bn * 64; e.nacc = 2; e.lat = 4;
            end
        end
        if (ack_dly != 0) e.lat = -1;
        e.fd = (a == NPIX - 1);
        e.cnt_now = m_fgout;
        m_fgacc += e.fg;
        if (e.fd) begin
            m_fgout = m_fgacc;
            m_fgacc = 0;
        end
        e.cnt_next = m_fgout;
        m_cnt = (a + 1) % NPIX;
        return e;
    endfunction

    // ---------------- compare process ----------------
    exp_t ce;
    bit   pend = 0;

    always @(negedge clk) begin
        if (rst_n && o_frame_done) fd_cnt++;
        if (rst_n && pend) begin
            pend = 0;
            chk("valid_one_cycle", o_valid, 0);
            chk("fg_count_after", o_fg_count, ce.cnt_next);
            chk("fg_hold", o_fg, ce.fg);
            chk("diff_hold", o_diff, ce.diff);
        end
        if (rst_n && o_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                ce = q.pop_front();
                chk("fg", o_fg, ce.fg);
                chk("diff", o_diff, ce.diff);
                chk("frame_done", o_frame_done, ce.fd);
                chk("fg_count", o_fg_count, ce.cnt_now);
                chk("accesses", n_acc - ce.acc_base, ce.nacc);
                if (ce.lat > 0) chk("latency", cyc - ce.acc_cyc, ce.lat);
                if (ce.nacc > 0) chk("access_addr", last_addr, ce.addr);
                if (ce.wr) chk("wdata", mem[ce.addr], ce.wd);
                pend = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic pix(input int r, input int g, input int b,
                       input bit sof, input int mode, input int th);
        exp_t e;
        int t;
        @(negedge clk);
        t = 0;
        while (!o_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        e = model(r, g, b, sof, mode, th);
        e.acc_cyc  = cyc;
        e.acc_base = n_acc;
        q.push_back(e);
        i_r = PIX_W'(r); i_g = PIX_W'(g); i_b = PIX_W'(b);
        i_sof = sof; i_mode = 2'(mode); i_thresh = PIX_W'(th);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_sof = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("valid_timeout", 0, 1);
            q.delete();
        end
    endtask

    int saved_cnt;
    int t;

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            mem[i] = '0;
            m_bg[i] = 0;
        end
        rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
        i_r = '0; i_g = '0; i_b = '0; i_mode = 2'b00; i_thresh = '0;
        i_sram_ack = 1'b0; i_sram_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_req", o_sram_req, 0);
        chk("rst_fg_count", o_fg_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", o_ready, 1);

        // LEARN frame, constant 400
        for (int i = 0; i < NPIX; i++) pix(400, 400, 400, i == 0, 1, 0);
        chk("learn_word0", mem[0], 16'd25600);
        chk("learn_word_last", mem[NPIX-1], 16'd25600);
        chk("learn_fd_pulses", fd_cnt, 1);
        chk("learn_fg_count", o_fg_count, 0);

        // DETECT frame
        pix(600, 600, 600, 1, 2, 100);
        chk("p0_diff", o_diff, 200);
        chk("p0_fg", o_fg, 1);
        chk("p0_word", mem[0], SEL ? 16'd25600 : 16'd27200);
        pix(480, 480, 480, 0, 2, 100);
        chk("p1_diff", o_diff, 80);
        chk("p1_fg", o_fg, 0);
        chk("p1_word", mem[1], 16'd26240);
        pix(100, 900, 50, 0, 0, 40);
        ack_dly = 5;
        for (int i = 3; i < 9; i++) pix((i * 97) % 1024, 300 + i, 500, 0, 1, 60);
        ack_dly = 0;
        for (int i = 9; i < NPIX; i++)
            pix((i * 53) % 1024, (i * 29 + 200) % 1024, 1023 - (i * 53) % 1024, 0, 2, 50);
        chk("detect_fd_pulses", fd_cnt, 2);

        // partial frame abandoned by sof
        saved_cnt = o_fg_count;
        for (int i = 0; i < 20; i++) pix(900 - i * 30, 100 + i, 700, i == 0, 3, 30);
        pix(10, 20, 30, 1, 2, 30);
        chk("sof_keeps_count", o_fg_count, saved_cnt);
        chk("sof_fd_pulses", fd_cnt, 2);

        // BYPASS at a new frame
        for (int i = 0; i < 5; i++) pix(i * 100, 50, 60, i == 0, 0, 10);

        // reset during a read
        ack_dly = 1000;
        @(negedge clk);
        t = 0;
        while (!o_ready && t < 50) begin @(negedge clk); t++; end
        i_r = 10'd300; i_g = 10'd300; i_b = 10'd300;
        i_sof = 1'b1; i_mode = 2'b10; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_sof = 1'b0;
        t = 0;
        while (!o_sram_req && t < 20) begin @(negedge clk); t++; end
        chk("req_before_reset", o_sram_req, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req", o_sram_req, 0);
        chk("abort_we", o_sram_we, 0);
        chk("abort_addr", o_sram_addr, 0);
        chk("abort_wdata", o_sram_wdata, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_fg", o_fg, 0);
        chk("abort_diff", o_diff, 0);
        chk("abort_fd", o_frame_done, 0);
        chk("abort_fg_count", o_fg_count, 0);
        chk("abort_ready", o_ready, 0);
        q.delete();
        m_cnt = 0; m_mode = 0; m_fgacc = 0; m_fgout = 0;
        ack_dly = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", o_ready, 1);
        pix(200, 200, 200, 1, 1, 0);
        pix(250, 250, 250, 0, 2, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
